// File: rtl/rr_mux_nx_nbit_pkg.sv
// rr_mux_nx_nbit_pkg
//   Shared definitions for the N-channel registered round-robin mux:
//   - mode encodings for the mode input
//   - width of the optional per-channel transfer counters
package rr_mux_nx_nbit_pkg;

    localparam logic MODE_FIXED = 1'b0;  // grant follows the sel port
    localparam logic MODE_RR    = 1'b1;  // grant rotates among valid channels

    localparam int XFER_CNT_W = 16;      // per-channel transfer counter width

endpackage : rr_mux_nx_nbit_pkg

// File: rtl/rr_mux_nx_nbit_arbiter.sv
// rr_mux_nx_nbit_arbiter
//   Purely combinational grant logic for rr_mux_nx_nbit. The rotating
//   pointer register is held by the top level and fed in through ptr.
//   Ports:
//     req       in   NUM_CH  per-channel request (channel valid)
//     ptr       in   SEL_W   first channel examined in round-robin mode
//     mode      in   1       MODE_FIXED or MODE_RR
//     sel       in   SEL_W   channel index used in fixed mode
//     grant     out  SEL_W   granted channel index
//     grant_vld out  1       a channel is granted this cycle
module rr_mux_nx_nbit_arbiter
    import rr_mux_nx_nbit_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_vld
);

    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any branch so that no
        // path leaves one unassigned, which would infer a latch.
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        if (mode == MODE_FIXED) begin
            // Fixed mode grants sel regardless of its valid; an index past
            // the last channel grants nothing.
            if (int'(sel) < NUM_CH) begin
                grant     = sel;
                grant_vld = 1'b1;
            end
        end else begin
            // Scan ptr, ptr+1, ... wrapping at NUM_CH; first requester wins.
            for (int i = 0; i < NUM_CH; i++) begin
                idx = int'(ptr) + i;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                if (!grant_vld && req[SEL_W'(idx)]) begin
                    grant     = SEL_W'(idx);
                    grant_vld = 1'b1;
                end
            end
        end
    end

endmodule : rr_mux_nx_nbit_arbiter

// File: rtl/rr_mux_nx_nbit.sv
// rr_mux_nx_nbit
//   N-channel, BUS_WIDTH-bit registered mux with valid/ready handshakes on
//   every input channel and on the single output. One channel is granted
//   per cycle, either by the sel port (fixed mode) or round-robin among the
//   valid channels. One output register stage; full throughput.
//   Optional feature macro: RR_MUX_XFER_CNT_EN adds the xfer_cnt output,
//   a 16-bit wrapping count of accepted transfers per channel.
//   Ports:
//     clk        in   1                 rising-edge clock
//     rst_n      in   1                 synchronous active-low reset
//     in_data    in   NUM_CH*BUS_WIDTH  channel k at [k*BUS_WIDTH +: BUS_WIDTH]
//     in_valid   in   NUM_CH            per-channel valid
//     in_ready   out  NUM_CH            per-channel ready (combinational)
//     mode       in   1                 0 = fixed (sel), 1 = round-robin
//     sel        in   SEL_W             channel index in fixed mode
//     out_data   out  BUS_WIDTH         registered selected data
//     out_sel    out  SEL_W             channel that produced out_data
//     out_valid  out  1                 output valid
//     out_ready  in   1                 downstream ready
//     xfer_cnt   out  NUM_CH*16         (RR_MUX_XFER_CNT_EN only) counters
module rr_mux_nx_nbit
    import rr_mux_nx_nbit_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*BUS_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           in_ready,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel,
    output logic [BUS_WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef RR_MUX_XFER_CNT_EN
    ,
    output logic [NUM_CH*XFER_CNT_W-1:0] xfer_cnt
`endif
);

    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     grant;
    logic                 grant_vld;
    logic                 load_en;
    logic                 grant_in_valid;
    logic                 xfer;
    logic [BUS_WIDTH-1:0] grant_data;

    rr_mux_nx_nbit_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .mode      (mode),
        .sel       (sel),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    // The output register can take a new word when empty or being drained.
    assign load_en = !out_valid || out_ready;

    // Channel decode with constant indices; ready goes only to the granted
    // channel and is independent of that channel's own valid.
    always_comb begin
        grant_data     = '0;
        grant_in_valid = 1'b0;
        in_ready       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_vld && (SEL_W'(k) == grant)) begin
                grant_data     = in_data[k*BUS_WIDTH +: BUS_WIDTH];
                grant_in_valid = in_valid[k];
                in_ready[k]    = load_en;
            end
        end
    end

    assign xfer = load_en && grant_vld && grant_in_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // updates from the values present before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            // While stalled (out_valid & !out_ready) the held word is frozen.
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= grant_data;
                    out_sel  <= grant;
                end
            end
            // Pointer advances past the winner only on round-robin transfers.
            if (xfer && (mode == MODE_RR)) begin
                if (int'(grant) == NUM_CH - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant + SEL_W'(1);
                end
            end
        end
    end

`ifdef RR_MUX_XFER_CNT_EN
    logic [XFER_CNT_W-1:0] cnt [NUM_CH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (!rst_n) begin
                cnt[k] <= '0;
            end else if (xfer && (SEL_W'(k) == grant)) begin
                cnt[k] <= cnt[k] + XFER_CNT_W'(1);  // wraps FFFF -> 0
            end
        end
    end

    always_comb begin
        xfer_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            xfer_cnt[k*XFER_CNT_W +: XFER_CNT_W] = cnt[k];
        end
    end
`endif

endmodule : rr_mux_nx_nbit
